// File: rtl/alu_operand_loader_if.sv
// Operand/opcode bus between the board-side inputs and the ALU operand loader.
// The slave modport is the loader; the master modport is the board or bench side.
interface alu_operand_loader_if;
  logic [7:0] sw;
  logic       btn_load;
  logic [3:0] btn_op;
  logic [7:0] A;
  logic [7:0] B;
  logic [3:0] Button;
  logic [1:0] state;
  logic       op_valid;

  modport master (
    output sw, btn_load, btn_op,
    input  A, B, Button, state, op_valid
  );

  modport slave (
    input  sw, btn_load, btn_op,
    output A, B, Button, state, op_valid
  );
endinterface

// File: rtl/alu_operand_loader.sv
// Debounced load A -> load B -> pick-op sequencer driving clean operands to the lab ALU.
// Optional SHOW-state idle timeout is enabled by defining ALU_LOADER_TIMEOUT_EN.
module alu_operand_loader #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
`ifdef ALU_LOADER_TIMEOUT_EN
  , parameter logic [31:0] TIMEOUT_CYCLES = 32'd500000000
`endif
) (
  input logic                 clk,
  input logic                 reset_n,
  alu_operand_loader_if.slave bus
);

  typedef enum logic [1:0] {
    StWaitA  = 2'b00,
    StWaitB  = 2'b01,
    StWaitOp = 2'b10,
    StShow   = 2'b11
  } state_e;

  logic [7:0]  sw_meta_q, sw_sync_q;
  logic [4:0]  btn_raw;
  logic [4:0]  btn_meta_q, btn_sync_q, btn_deb_q, btn_deb_dly_q, press_q;
  logic [15:0] deb_cnt_q [5];

  state_e      state_q;
  logic [7:0]  a_q, b_q;
  logic [3:0]  button_q;
  logic        op_valid_q;

  logic        load_ev;
  logic [3:0]  op_ev;
  logic        op_single;

  // Bit 0 is the load button, bits 4:1 the op buttons.
  assign btn_raw = {bus.btn_op, bus.btn_load};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sw_meta_q     <= '0;
      sw_sync_q     <= '0;
      btn_meta_q    <= '0;
      btn_sync_q    <= '0;
      btn_deb_q     <= '0;
      btn_deb_dly_q <= '0;
      press_q       <= '0;
      for (int i = 0; i < 5; i++) begin
        deb_cnt_q[i] <= '0;
      end
    end else begin
      sw_meta_q  <= bus.sw;
      sw_sync_q  <= sw_meta_q;
      btn_meta_q <= btn_raw;
      btn_sync_q <= btn_meta_q;
      for (int i = 0; i < 5; i++) begin
        if (btn_sync_q[i] == btn_deb_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DEBOUNCE_CYCLES - 16'd1) begin
          btn_deb_q[i] <= btn_sync_q[i];
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + 16'd1;
        end
      end
      // Registered rising-edge detect: exactly one cycle per accepted press.
      btn_deb_dly_q <= btn_deb_q;
      press_q       <= btn_deb_q & ~btn_deb_dly_q;
    end
  end

  assign load_ev   = press_q[0];
  assign op_ev     = press_q[4:1];
  assign op_single = $onehot(op_ev);

`ifdef ALU_LOADER_TIMEOUT_EN
  logic [31:0] to_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StWaitA;
      a_q        <= '0;
      b_q        <= '0;
      button_q   <= '0;
      op_valid_q <= 1'b0;
`ifdef ALU_LOADER_TIMEOUT_EN
      to_cnt_q   <= '0;
`endif
    end else begin
      op_valid_q <= 1'b0;
      unique case (state_q)
        StWaitA: begin
          if (load_ev) begin
            a_q     <= sw_sync_q;
            state_q <= StWaitB;
          end
        end
        StWaitB: begin
          if (load_ev) begin
            b_q     <= sw_sync_q;
            state_q <= StWaitOp;
          end
        end
        StWaitOp: begin
          if (load_ev) begin
            state_q <= StWaitA;
          end else if (op_single) begin
            button_q   <= op_ev;
            op_valid_q <= 1'b1;
            state_q    <= StShow;
`ifdef ALU_LOADER_TIMEOUT_EN
            to_cnt_q   <= '0;
`endif
          end
        end
        StShow: begin
`ifdef ALU_LOADER_TIMEOUT_EN
          if (load_ev || (to_cnt_q == TIMEOUT_CYCLES - 32'd1)) begin
            button_q <= '0;
            state_q  <= StWaitA;
          end else begin
            to_cnt_q <= (|op_ev) ? '0 : to_cnt_q + 32'd1;
            if (op_single) begin
              button_q   <= op_ev;
              op_valid_q <= 1'b1;
            end
          end
`else
          if (load_ev) begin
            button_q <= '0;
            state_q  <= StWaitA;
          end else if (op_single) begin
            button_q   <= op_ev;
            op_valid_q <= 1'b1;
          end
`endif
        end
      endcase
    end
  end

  assign bus.A        = a_q;
  assign bus.B        = b_q;
  assign bus.Button   = button_q;
  assign bus.state    = state_q;
  assign bus.op_valid = op_valid_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader: scoreboard of expected output snapshots plus
// exact-latency, bounce, multi-op, load-priority and reset checks (DEBOUNCE_CYCLES=4).
module tb_alu_operand_loader;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] btn;
    logic [1:0] st;
  } snap_t;

  logic clk;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   pulses = 0;
  bit   mon_en = 1'b0;
  snap_t exp_q[$];

  alu_operand_loader_if bus ();

`ifdef ALU_LOADER_TIMEOUT_EN
  alu_operand_loader #(
    .DEBOUNCE_CYCLES(16'd4),
    .TIMEOUT_CYCLES (32'd20)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );
`else
  alu_operand_loader #(
    .DEBOUNCE_CYCLES(16'd4)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic snap_t cur_snap();
    return '{a: bus.A, b: bus.B, btn: bus.Button, st: bus.state};
  endfunction

  function automatic snap_t mk(input logic [7:0] a, input logic [7:0] b,
                               input logic [3:0] btn, input logic [1:0] st);
    return '{a: a, b: b, btn: btn, st: st};
  endfunction

  // Any change of A/B/Button/state must match the next expected snapshot.
  initial begin
    snap_t prev, cur;
    bit    prev_ov;
    prev    = '0;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      cur = cur_snap();
      if (mon_en) begin
        if (cur !== prev) begin
          if (exp_q.size() == 0) begin
            check("unexpected_change_queue_size", 32'(exp_q.size()), 32'd1);
          end else begin
            check("output_change", 32'(cur), 32'(exp_q.pop_front()));
          end
        end
        if (bus.op_valid === 1'b1) begin
          pulses++;
          check("op_valid_single_cycle", {31'd0, prev_ov}, 32'd0);
          check("op_valid_ctx", {26'd0, bus.state, ($onehot(bus.Button) ? 4'd1 : 4'd0)},
                {26'd0, 2'b11, 4'd1});
        end
      end
      prev    = cur;
      prev_ov = (bus.op_valid === 1'b1);
    end
  end

  task automatic wait_edge(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic press(input logic ld, input logic [3:0] op, input int hold);
    bus.btn_load = ld;
    bus.btn_op   = op;
    repeat (hold) @(negedge clk);
    bus.btn_load = 1'b0;
    bus.btn_op   = 4'd0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int n;
    int e;
    reset_n      = 1'b0;
    bus.sw       = 8'h00;
    bus.btn_load = 1'b0;
    bus.btn_op   = 4'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_A", 32'(bus.A), 32'h00);
    check("rst_B", 32'(bus.B), 32'h00);
    check("rst_Button", 32'(bus.Button), 32'h0);
    check("rst_state", 32'(bus.state), 32'h0);
    check("rst_op_valid", 32'(bus.op_valid), 32'h0);
    mon_en = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_pulses", 32'(pulses), 32'd0);

    // Load A with exact latency: raw high sampled at edge n, A visible after edge n+7.
    bus.sw = 8'h2A;
    exp_q.push_back(mk(8'h2A, 8'h00, 4'h0, 2'b01));
    bus.btn_load = 1'b1;
    n = cyc + 1;
    wait_edge(n + 6);
    check("A_not_yet", 32'(bus.A), 32'h00);
    wait_edge(n + 7);
    check("A_loaded", 32'(bus.A), 32'h2A);
    check("state_wait_b", 32'(bus.state), 32'h1);
    wait_edge(n + 9);
    bus.btn_load = 1'b0;
    repeat (8) @(negedge clk);

    // Bouncing load button must not produce an event.
    bus.sw = 8'h15;
    for (int i = 0; i < 10; i++) begin
      bus.btn_load = 1'b1;
      repeat (2) @(negedge clk);
      bus.btn_load = 1'b0;
      repeat (2) @(negedge clk);
    end
    check("bounce_state", 32'(bus.state), 32'h1);
    check("bounce_B", 32'(bus.B), 32'h00);
    exp_q.push_back(mk(8'h2A, 8'h15, 4'h0, 2'b10));
    press(1'b1, 4'd0, 10);
    check("B_loaded", 32'(bus.B), 32'h15);
    check("state_wait_op", 32'(bus.state), 32'h2);
    check("wait_op_Button", 32'(bus.Button), 32'h0);

`ifdef ALU_LOADER_TIMEOUT_EN
    bus.btn_op = 4'b0010;
    exp_q.push_back(mk(8'h2A, 8'h15, 4'b0010, 2'b11));
    n = cyc + 1;
    wait_edge(n + 7);
    e = n + 7;
    check("to_enter_show", 32'(bus.state), 32'h3);
    bus.btn_op = 4'd0;
    wait_edge(e + 7);
    bus.btn_op = 4'b1000;
    exp_q.push_back(mk(8'h2A, 8'h15, 4'b1000, 2'b11));
    wait_edge(e + 14);
    check("to_pre_restart_Button", 32'(bus.Button), 32'b0010);
    wait_edge(e + 15);
    check("to_restart_Button", 32'(bus.Button), 32'b1000);
    bus.btn_op = 4'd0;
    wait_edge(e + 20);
    check("to_restarted_state", 32'(bus.state), 32'h3);
    wait_edge(e + 34);
    check("to_before_expiry", 32'(bus.state), 32'h3);
    exp_q.push_back(mk(8'h2A, 8'h15, 4'h0, 2'b00));
    wait_edge(e + 35);
    check("to_expired_state", 32'(bus.state), 32'h0);
    check("to_expired_Button", 32'(bus.Button), 32'h0);
    check("to_pulses", 32'(pulses), 32'd2);
    repeat (4) @(negedge clk);
`else
    exp_q.push_back(mk(8'h2A, 8'h15, 4'b0010, 2'b11));
    press(1'b0, 4'b0010, 10);
    check("op_sub_Button", 32'(bus.Button), 32'b0010);
    check("op_sub_state", 32'(bus.state), 32'h3);
    check("op_sub_pulses", 32'(pulses), 32'd1);

    press(1'b0, 4'b0101, 10);
    check("multi_op_Button", 32'(bus.Button), 32'b0010);
    check("multi_op_pulses", 32'(pulses), 32'd1);

    exp_q.push_back(mk(8'h2A, 8'h15, 4'b1000, 2'b11));
    press(1'b0, 4'b1000, 10);
    check("op_or_Button", 32'(bus.Button), 32'b1000);
    check("op_or_pulses", 32'(pulses), 32'd2);

    // Load and op together: load wins.
    exp_q.push_back(mk(8'h2A, 8'h15, 4'h0, 2'b00));
    press(1'b1, 4'b0001, 10);
    check("load_wins_state", 32'(bus.state), 32'h0);
    check("load_wins_Button", 32'(bus.Button), 32'h0);
    check("load_wins_A", 32'(bus.A), 32'h2A);
    check("load_wins_B", 32'(bus.B), 32'h15);
    check("load_wins_pulses", 32'(pulses), 32'd2);
`endif

    // Reset in the middle of a debounce discards everything.
    bus.btn_load = 1'b1;
    repeat (3) @(negedge clk);
    exp_q.push_back(mk(8'h00, 8'h00, 4'h0, 2'b00));
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_A", 32'(bus.A), 32'h00);
    check("mid_rst_B", 32'(bus.B), 32'h00);
    check("mid_rst_state", 32'(bus.state), 32'h0);
    bus.btn_load = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    check("post_rst_state", 32'(bus.state), 32'h0);
    check("post_rst_A", 32'(bus.A), 32'h00);
    check("post_rst_pulses", 32'(pulses), 32'd2);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
